// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between fetch and load/store, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants when both sides are pending; otherwise data wins.
module sram_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2;
  logic [1:0] state;
  logic owner, inst_done, data_done, grant_data, grant, complete, advance;
  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;
  assign grant = state == IDLE && (inst_stall || data_stall);
  assign complete = state == WAIT && bus_data_ok;
  assign advance = ~inst_stall & ~data_stall;
  assign bus_req = state == ADDR;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;
  assign grant_data = data_stall & (~inst_stall | ~last_data);
  always_ff @(posedge clk)
    last_data <= rst ? 1'b1 : grant ? grant_data : last_data;
`else
  assign grant_data = data_stall;
`endif
  // owner: 0 = inst, 1 = data; a result whose requester dropped req is kept in the hold reg but not flagged done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      bus_wr <= 1'b0;
      bus_size <= 2'b00;
      bus_addr <= 32'd0;
      bus_wdata <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      inst_done <= 1'b0;
      data_done <= 1'b0;
    end else begin
      if (grant) begin
        state <= ADDR;
        owner <= grant_data;
        bus_wr <= grant_data & data_we;
        bus_size <= grant_data ? data_size : 2'b10;
        bus_addr <= grant_data ? data_addr : inst_addr;
        bus_wdata <= grant_data ? data_wdata : 32'd0;
      end else if (state == ADDR && bus_addr_ok) state <= WAIT;
      else if (complete) state <= IDLE;
      if (complete && owner) data_rdata <= bus_rdata;
      if (complete && !owner) inst_rdata <= bus_rdata;
      inst_done <= (complete && !owner && inst_req) || (inst_done && !advance);
      data_done <= (complete && owner && data_req) || (data_done && !advance);
    end
  end
endmodule
